// File: rtl/scalar_rs_pkg.sv
// Shared widths, entry layout and the operand snoop helper for the scalar reservation station.
package scalar_rs_pkg;

  localparam int unsigned RsTypeBit   = 5;
  localparam int unsigned RobWidthBit = 4;
  localparam int unsigned RsSizeBit   = 3;
  localparam int unsigned RsSize      = 1 << RsSizeBit;

  typedef logic [RobWidthBit-1:0] rob_id_t;

  // One result broadcast bus (ALU or LSB).
  typedef struct packed {
    logic        rdy;
    rob_id_t     rob_id;
    logic [31:0] value;
  } bcast_t;

  // Operand: h=1 means still waiting on producer tag q.
  typedef struct packed {
    logic        h;
    rob_id_t     q;
    logic [31:0] v;
  } opnd_t;

  typedef struct packed {
    logic                 busy;
    logic [RsTypeBit-1:0] work_type;
    rob_id_t              rob_id;
    opnd_t                j;
    opnd_t                k;
  } entry_t;

  // Capture a pending operand from either broadcast; ALU wins if both carry the tag.
  function automatic opnd_t snoop(opnd_t o, bcast_t alu, bcast_t lsb);
    opnd_t r;
    r = o;
    if (o.h) begin
      if (alu.rdy && (alu.rob_id == o.q)) begin
        r.v = alu.value;
        r.h = 1'b0;
      end else if (lsb.rdy && (lsb.rob_id == o.q)) begin
        r.v = lsb.value;
        r.h = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_first_set.sv
// Lowest-set-bit priority encoder: index of the first 1 and an any-set flag.
module rs_first_set #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]         vec_i,
  output logic [$clog2(WIDTH)-1:0] idx_o,
  output logic                     any_o
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = ($clog2(WIDTH))'(i);
    end
    any_o = |vec_i;
  end

endmodule

// File: rtl/scalar_rs.sv
// Reservation station for scalar_alu: holds ops until both operands arrive, issues one per cycle.
module scalar_rs
  import scalar_rs_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush,
  input  logic                   inst_valid,
  input  logic [RsTypeBit-1:0]   inst_type,
  input  logic [RobWidthBit-1:0] inst_rob_id,
  input  logic [31:0]            inst_vj,
  input  logic [31:0]            inst_vk,
  input  logic                   inst_hj,
  input  logic                   inst_hk,
  input  logic [RobWidthBit-1:0] inst_qj,
  input  logic [RobWidthBit-1:0] inst_qk,
  input  logic                   alu_rdy,
  input  logic [RobWidthBit-1:0] alu_rob_id,
  input  logic [31:0]            alu_value,
  input  logic                   lsb_rdy,
  input  logic [RobWidthBit-1:0] lsb_rob_id,
  input  logic [31:0]            lsb_value,
  output logic                   full,
  output logic                   exe_valid,
  output logic [RsTypeBit-1:0]   exe_type,
  output logic [31:0]            exe_r1,
  output logic [31:0]            exe_r2,
  output logic [RobWidthBit-1:0] exe_rob_id
);

  entry_t entry_q [RsSize];
  entry_t entry_d [RsSize];

  logic                   exe_valid_q, exe_valid_d;
  logic [RsTypeBit-1:0]   exe_type_q, exe_type_d;
  logic [31:0]            exe_r1_q, exe_r1_d;
  logic [31:0]            exe_r2_q, exe_r2_d;
  logic [RobWidthBit-1:0] exe_rob_id_q, exe_rob_id_d;

  logic [RsSize-1:0]    busy, ready;
  logic [RsSizeBit-1:0] alloc_idx, sel_idx;
  logic                 alloc_any, sel_any;

  bcast_t alu_b, lsb_b;
  opnd_t  ins_j, ins_k;

  assign alu_b = '{rdy: alu_rdy, rob_id: alu_rob_id, value: alu_value};
  assign lsb_b = '{rdy: lsb_rdy, rob_id: lsb_rob_id, value: lsb_value};
  assign ins_j = '{h: inst_hj, q: inst_qj, v: inst_vj};
  assign ins_k = '{h: inst_hk, q: inst_qk, v: inst_vk};

  // Occupancy and ready masks from registered state only (no wakeup bypass into select).
  always_comb begin
    busy  = '0;
    ready = '0;
    for (int i = 0; i < RsSize; i++) begin
      busy[i]  = entry_q[i].busy;
      ready[i] = entry_q[i].busy && !entry_q[i].j.h && !entry_q[i].k.h;
    end
  end

  assign full = &busy;

  rs_first_set #(.WIDTH(RsSize)) u_alloc (
    .vec_i (~busy),
    .idx_o (alloc_idx),
    .any_o (alloc_any)
  );

  rs_first_set #(.WIDTH(RsSize)) u_select (
    .vec_i (ready),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  // Next state: freeze when !rdy_in, else flush, else wakeup + issue + insert.
  always_comb begin
    entry_t new_e;
    entry_d      = entry_q;
    exe_valid_d  = exe_valid_q;
    exe_type_d   = exe_type_q;
    exe_r1_d     = exe_r1_q;
    exe_r2_d     = exe_r2_q;
    exe_rob_id_d = exe_rob_id_q;

    new_e           = '0;
    new_e.busy      = 1'b1;
    new_e.work_type = inst_type;
    new_e.rob_id    = inst_rob_id;
    new_e.j         = snoop(ins_j, alu_b, lsb_b);
    new_e.k         = snoop(ins_k, alu_b, lsb_b);

    if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < RsSize; i++) entry_d[i].busy = 1'b0;
        exe_valid_d = 1'b0;
      end else begin
        for (int i = 0; i < RsSize; i++) begin
          if (entry_q[i].busy) begin
            entry_d[i].j = snoop(entry_q[i].j, alu_b, lsb_b);
            entry_d[i].k = snoop(entry_q[i].k, alu_b, lsb_b);
          end
        end
        if (sel_any) begin
          exe_valid_d             = 1'b1;
          exe_type_d              = entry_q[sel_idx].work_type;
          exe_r1_d                = entry_q[sel_idx].j.v;
          exe_r2_d                = entry_q[sel_idx].k.v;
          exe_rob_id_d            = entry_q[sel_idx].rob_id;
          entry_d[sel_idx].busy   = 1'b0;
        end else begin
          exe_valid_d = 1'b0;
        end
        // alloc_any is low exactly when full, so an insert while full is dropped.
        if (inst_valid && alloc_any) entry_d[alloc_idx] = new_e;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RsSize; i++) entry_q[i] <= '0;
      exe_valid_q  <= 1'b0;
      exe_type_q   <= '0;
      exe_r1_q     <= '0;
      exe_r2_q     <= '0;
      exe_rob_id_q <= '0;
    end else begin
      entry_q      <= entry_d;
      exe_valid_q  <= exe_valid_d;
      exe_type_q   <= exe_type_d;
      exe_r1_q     <= exe_r1_d;
      exe_r2_q     <= exe_r2_d;
      exe_rob_id_q <= exe_rob_id_d;
    end
  end

  assign exe_valid  = exe_valid_q;
  assign exe_type   = exe_type_q;
  assign exe_r1     = exe_r1_q;
  assign exe_r2     = exe_r2_q;
  assign exe_rob_id = exe_rob_id_q;

endmodule

// File: tb/tb_scalar_rs.sv
// Directed self-checking bench for scalar_rs.
module tb_scalar_rs;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, inst_valid, inst_hj, inst_hk;
  logic [4:0]  inst_type;
  logic [3:0]  inst_rob_id, inst_qj, inst_qk;
  logic [31:0] inst_vj, inst_vk;
  logic        alu_rdy, lsb_rdy;
  logic [3:0]  alu_rob_id, lsb_rob_id;
  logic [31:0] alu_value, lsb_value;
  logic        full, exe_valid;
  logic [4:0]  exe_type;
  logic [31:0] exe_r1, exe_r2;
  logic [3:0]  exe_rob_id;

  int checks = 0;
  int errors = 0;

  scalar_rs dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .rdy_in      (rdy),
    .flush       (flush),
    .inst_valid  (inst_valid),
    .inst_type   (inst_type),
    .inst_rob_id (inst_rob_id),
    .inst_vj     (inst_vj),
    .inst_vk     (inst_vk),
    .inst_hj     (inst_hj),
    .inst_hk     (inst_hk),
    .inst_qj     (inst_qj),
    .inst_qk     (inst_qk),
    .alu_rdy     (alu_rdy),
    .alu_rob_id  (alu_rob_id),
    .alu_value   (alu_value),
    .lsb_rdy     (lsb_rdy),
    .lsb_rob_id  (lsb_rob_id),
    .lsb_value   (lsb_value),
    .full        (full),
    .exe_valid   (exe_valid),
    .exe_type    (exe_type),
    .exe_r1      (exe_r1),
    .exe_r2      (exe_r2),
    .exe_rob_id  (exe_rob_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; inst_valid = 0; inst_hj = 0; inst_hk = 0; inst_type = 0; inst_rob_id = 0;
    inst_qj = 0; inst_qk = 0; inst_vj = 0; inst_vk = 0;
    alu_rdy = 0; alu_rob_id = 0; alu_value = 0; lsb_rdy = 0; lsb_rob_id = 0; lsb_value = 0;
  endtask

  task automatic dispatch(input logic [4:0] ty, input logic [3:0] rob, input logic hj,
                          input logic [3:0] qj, input logic [31:0] vj, input logic hk,
                          input logic [3:0] qk, input logic [31:0] vk);
    inst_valid = 1; inst_type = ty; inst_rob_id = rob;
    inst_hj = hj; inst_qj = qj; inst_vj = vj; inst_hk = hk; inst_qk = qk; inst_vk = vk;
  endtask

  initial begin
    idle_inputs();
    rst = 1; rdy = 1;
    tick(); tick();
    rst = 0;

    // Reset then idle
    for (int c = 0; c < 10; c++) begin
      chk("idle_valid", 32'(exe_valid), 0);
      chk("idle_full", 32'(full), 0);
      chk("idle_r1", exe_r1, 0);
      chk("idle_r2", exe_r2, 0);
      chk("idle_rob", 32'(exe_rob_id), 0);
      chk("idle_type", 32'(exe_type), 0);
      tick();
    end

    // Ready insert issues one cycle after dispatch
    dispatch(5'd0, 4'd2, 0, 0, 32'd3, 0, 0, 32'd4);
    tick(); idle_inputs();
    chk("rdy_ins_noissue", 32'(exe_valid), 0);
    tick();
    chk("rdy_ins_valid", 32'(exe_valid), 1);
    chk("rdy_ins_r1", exe_r1, 3);
    chk("rdy_ins_r2", exe_r2, 4);
    chk("rdy_ins_rob", 32'(exe_rob_id), 2);
    tick();
    chk("rdy_ins_drop", 32'(exe_valid), 0);
    chk("rdy_ins_r1_hold", exe_r1, 3);

    // Dependency on tag 5; tag 6 must not wake it
    dispatch(5'd1, 4'd3, 1, 4'd5, 32'd0, 0, 0, 32'd7);
    tick(); idle_inputs();
    alu_rdy = 1; alu_rob_id = 4'd6; alu_value = 32'h99;
    tick();
    chk("dep_wait1", 32'(exe_valid), 0);
    tick();
    chk("dep_wrongtag", 32'(exe_valid), 0);
    alu_rob_id = 4'd5; alu_value = 32'h10;
    tick(); idle_inputs();
    chk("dep_wake_nobypass", 32'(exe_valid), 0);
    tick();
    chk("dep_valid", 32'(exe_valid), 1);
    chk("dep_r1", exe_r1, 32'h10);
    chk("dep_r2", exe_r2, 7);
    chk("dep_rob", 32'(exe_rob_id), 3);
    chk("dep_type", 32'(exe_type), 1);
    tick();
    chk("dep_drop", 32'(exe_valid), 0);

    // Same-cycle capture from LSB broadcast at insert
    dispatch(5'd0, 4'd4, 0, 0, 32'h55, 1, 4'd9, 32'd0);
    lsb_rdy = 1; lsb_rob_id = 4'd9; lsb_value = 32'hAB;
    tick(); idle_inputs();
    chk("cap_noissue", 32'(exe_valid), 0);
    tick();
    chk("cap_valid", 32'(exe_valid), 1);
    chk("cap_r1", exe_r1, 32'h55);
    chk("cap_r2", exe_r2, 32'hAB);
    chk("cap_rob", 32'(exe_rob_id), 4);
    tick();
    chk("cap_drop", 32'(exe_valid), 0);

    // Fill all 8 entries: entry i waits on tag i+1, rob id i+8, vk 0x100+i
    for (int i = 0; i < 8; i++) begin
      chk("fill_notfull", 32'(full), 0);
      dispatch(5'd0, 4'(i + 8), 1, 4'(i + 1), 32'd0, 0, 0, 32'h100 + 32'(i));
      tick();
    end
    idle_inputs();
    chk("fill_full", 32'(full), 1);
    chk("fill_noissue", 32'(exe_valid), 0);

    // Insert while full is ignored (would otherwise issue a ready op)
    dispatch(5'd0, 4'd1, 0, 0, 32'hDEAD, 0, 0, 32'd0);
    tick(); idle_inputs();
    chk("ovf_full", 32'(full), 1);
    tick();
    chk("ovf_noissue", 32'(exe_valid), 0);

    // Wake entries 3 (tag 4 via ALU) and 6 (tag 7 via LSB) together
    alu_rdy = 1; alu_rob_id = 4'd4; alu_value = 32'h33;
    lsb_rdy = 1; lsb_rob_id = 4'd7; lsb_value = 32'h66;
    tick(); idle_inputs();
    chk("wake2_noissue", 32'(exe_valid), 0);
    chk("wake2_full", 32'(full), 1);
    tick();
    chk("iss3_valid", 32'(exe_valid), 1);
    chk("iss3_r1", exe_r1, 32'h33);
    chk("iss3_r2", exe_r2, 32'h103);
    chk("iss3_rob", 32'(exe_rob_id), 11);
    chk("iss3_full", 32'(full), 0);
    tick();
    chk("iss6_valid", 32'(exe_valid), 1);
    chk("iss6_r1", exe_r1, 32'h66);
    chk("iss6_r2", exe_r2, 32'h106);
    chk("iss6_rob", 32'(exe_rob_id), 14);
    tick();
    chk("iss_done", 32'(exe_valid), 0);

    // Flush with a same-cycle ready insert that must be dropped
    flush = 1;
    dispatch(5'd0, 4'd1, 0, 0, 32'h77, 0, 0, 32'd0);
    tick(); idle_inputs();
    chk("flush_full", 32'(full), 0);
    chk("flush_valid", 32'(exe_valid), 0);
    tick();
    chk("flush_drop_ins", 32'(exe_valid), 0);
    alu_rdy = 1; alu_rob_id = 4'd1; alu_value = 32'h1;
    lsb_rdy = 1; lsb_rob_id = 4'd2; lsb_value = 32'h2;
    tick(); idle_inputs();
    tick();
    chk("flush_stale1", 32'(exe_valid), 0);
    tick();
    chk("flush_stale2", 32'(exe_valid), 0);

    // Freeze: wakeup during rdy_in=0 is lost, exe_* held
    dispatch(5'd2, 4'd5, 1, 4'd5, 32'd0, 0, 0, 32'd9);
    tick(); idle_inputs();
    rdy = 0;
    alu_rdy = 1; alu_rob_id = 4'd5; alu_value = 32'h21;
    tick();
    chk("frz_valid", 32'(exe_valid), 0);
    chk("frz_r1_hold", exe_r1, 32'h66);
    tick(); idle_inputs();
    tick();
    chk("frz_valid2", 32'(exe_valid), 0);
    rdy = 1;
    tick();
    chk("frz_missed_wake", 32'(exe_valid), 0);
    alu_rdy = 1; alu_rob_id = 4'd5; alu_value = 32'h21;
    tick(); idle_inputs();
    chk("frz_wake_noissue", 32'(exe_valid), 0);
    tick();
    chk("frz_iss_valid", 32'(exe_valid), 1);
    chk("frz_iss_r1", exe_r1, 32'h21);
    chk("frz_iss_r2", exe_r2, 9);
    chk("frz_iss_rob", 32'(exe_rob_id), 5);
    chk("frz_iss_type", 32'(exe_type), 2);
    rdy = 0;
    tick(); tick();
    chk("frz_hold_valid", 32'(exe_valid), 1);
    chk("frz_hold_r1", exe_r1, 32'h21);
    rdy = 1;
    tick();
    chk("frz_release", 32'(exe_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
